// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data stage.
// One access in flight at a time; owner gets a one-cycle Valid pulse on completion.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic              IfValid,
  output logic [DATA_W-1:0] IfRdata,
  input  logic              DmReq,
  input  logic              DmWe,
  input  logic [1:0]        DmSize,
  input  logic [ADDR_W-1:0] DmAddr,
  input  logic [DATA_W-1:0] DmWdata,
  output logic              DmValid,
  output logic [DATA_W-1:0] DmRdata,
  output logic              DmErr,
  output logic              MemEn,
  output logic              MemWe,
  output logic [1:0]        MemSize,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              StallIF,
  output logic              StallMEM
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              own_dm_q, own_dm_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic grant_if;
  logic dm_bad;
  logic issue;

  assign grant_if = IfReq && (!DmReq || (starve_q == STV_W'(STARVE_MAX)));
  assign dm_bad   = ((DmSize == 2'd1) && DmAddr[0])
                 || ((DmSize == 2'd2) && (DmAddr[1:0] != 2'b00))
                 || (DmSize == 2'd3);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    own_dm_d   = own_dm_q;
    we_d       = we_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    issue      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (IfReq || DmReq) begin
          own_dm_d = !grant_if;
          if (grant_if) begin
            starve_d = '0;
          end else if (IfReq && (starve_q != STV_W'(STARVE_MAX))) begin
            starve_d = starve_q + STV_W'(1);
          end
          // A rejected DM access never touches memory and completes next cycle.
          if (!grant_if && dm_bad) begin
            err_d      = 1'b1;
            we_d       = DmWe;
            dm_rdata_d = '0;
            state_d    = S_DONE;
          end else begin
            issue   = 1'b1;
            err_d   = 1'b0;
            we_d    = !grant_if && DmWe;
            cnt_d   = CNT_W'(MEM_LAT - 1);
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (own_dm_q) begin
            dm_rdata_d = we_q ? '0 : MemRdata;
          end else begin
            if_rdata_d = MemRdata;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Issue strobe is combinational from IDLE, so it is also held off while Reset is low.
  always_comb begin
    MemEn    = issue && Reset;
    MemWe    = 1'b0;
    MemSize  = 2'd0;
    MemAddr  = '0;
    MemWdata = '0;
    if (MemEn) begin
      if (grant_if) begin
        MemSize = 2'd2;
        MemAddr = IfAddr;
      end else begin
        MemWe    = DmWe;
        MemSize  = DmSize;
        MemAddr  = DmAddr;
        MemWdata = DmWdata;
      end
    end
  end

  assign IfValid  = (state_q == S_DONE) && !own_dm_q;
  assign DmValid  = (state_q == S_DONE) && own_dm_q;
  assign DmErr    = DmValid && err_q;
  assign IfRdata  = if_rdata_q;
  assign DmRdata  = dm_rdata_q;
  assign StallIF  = IfReq && !IfValid;
  assign StallMEM = DmReq && !DmValid;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      own_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      own_dm_q   <= own_dm_d;
      we_q       <= we_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (MEM_LAT=2 main instance,
// MEM_LAT=1 second instance for back-to-back fetch timing).
module tb_mem_port_arbiter;

  logic        Clk;
  logic        Reset;
  logic        IfReq;
  logic [31:0] IfAddr;
  logic        IfValid;
  logic [31:0] IfRdata;
  logic        DmReq;
  logic        DmWe;
  logic [1:0]  DmSize;
  logic [31:0] DmAddr;
  logic [31:0] DmWdata;
  logic        DmValid;
  logic [31:0] DmRdata;
  logic        DmErr;
  logic        MemEn;
  logic        MemWe;
  logic [1:0]  MemSize;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata;
  logic        StallIF;
  logic        StallMEM;

  logic        IfReq2;
  logic [31:0] IfAddr2;
  logic        IfValid2;
  logic [31:0] IfRdata2;
  logic        DmValid2;
  logic [31:0] DmRdata2;
  logic        DmErr2;
  logic        MemEn2;
  logic        MemWe2;
  logic [1:0]  MemSize2;
  logic [31:0] MemAddr2;
  logic [31:0] MemWdata2;
  logic [31:0] MemRdata2;
  logic        StallIF2;
  logic        StallMEM2;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfValid(IfValid), .IfRdata(IfRdata),
    .DmReq(DmReq), .DmWe(DmWe), .DmSize(DmSize), .DmAddr(DmAddr), .DmWdata(DmWdata),
    .DmValid(DmValid), .DmRdata(DmRdata), .DmErr(DmErr),
    .MemEn(MemEn), .MemWe(MemWe), .MemSize(MemSize), .MemAddr(MemAddr),
    .MemWdata(MemWdata), .MemRdata(MemRdata),
    .StallIF(StallIF), .StallMEM(StallMEM)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .IfReq(IfReq2), .IfAddr(IfAddr2), .IfValid(IfValid2), .IfRdata(IfRdata2),
    .DmReq(1'b0), .DmWe(1'b0), .DmSize(2'd0), .DmAddr(32'd0), .DmWdata(32'd0),
    .DmValid(DmValid2), .DmRdata(DmRdata2), .DmErr(DmErr2),
    .MemEn(MemEn2), .MemWe(MemWe2), .MemSize(MemSize2), .MemAddr(MemAddr2),
    .MemWdata(MemWdata2), .MemRdata(MemRdata2),
    .StallIF(StallIF2), .StallMEM(StallMEM2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory content is a fixed function of address; outside the valid slot the bus carries junk.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h2010_0045;
  endfunction

  logic [32:0] p0 = '0;
  logic [32:0] p1 = '0;
  logic [32:0] q0 = '0;
  always @(posedge Clk) begin
    p0 <= {MemEn & ~MemWe, MemAddr};
    p1 <= p0;
    q0 <= {MemEn2 & ~MemWe2, MemAddr2};
  end
  assign MemRdata  = p1[32] ? memf(p1[31:0]) : 32'hDEAD_BEEF;
  assign MemRdata2 = q0[32] ? memf(q0[31:0]) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ifreq;
    logic [31:0] ifaddr;
    logic        dmreq;
    logic        dmwe;
    logic [1:0]  dmsize;
    logic [31:0] dmaddr;
    logic [31:0] dmwdata;
    logic        e_memen;
    logic        e_memwe;
    logic [1:0]  e_memsize;
    logic [31:0] e_memaddr;
    logic [31:0] e_memwdata;
    logic        e_ifv;
    logic        e_dmv;
    logic        e_err;
    logic        e_stif;
    logic        e_stmem;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t V(
    input logic [31:0] ifreq, input logic [31:0] ifaddr,
    input logic [31:0] dmreq, input logic [31:0] dmwe, input logic [31:0] dmsize,
    input logic [31:0] dmaddr, input logic [31:0] dmwdata,
    input logic [31:0] memen, input logic [31:0] memwe, input logic [31:0] memsize,
    input logic [31:0] memaddr, input logic [31:0] memwdata,
    input logic [31:0] ifv, input logic [31:0] dmv, input logic [31:0] err,
    input logic [31:0] stif, input logic [31:0] stmem, input logic [31:0] rdata);
    vec_t v;
    v.ifreq      = ifreq[0];
    v.ifaddr     = ifaddr;
    v.dmreq      = dmreq[0];
    v.dmwe       = dmwe[0];
    v.dmsize     = dmsize[1:0];
    v.dmaddr     = dmaddr;
    v.dmwdata    = dmwdata;
    v.e_memen    = memen[0];
    v.e_memwe    = memwe[0];
    v.e_memsize  = memsize[1:0];
    v.e_memaddr  = memaddr;
    v.e_memwdata = memwdata;
    v.e_ifv      = ifv[0];
    v.e_dmv      = dmv[0];
    v.e_err      = err[0];
    v.e_stif     = stif[0];
    v.e_stmem    = stmem[0];
    v.e_rdata    = rdata;
    return v;
  endfunction

  vec_t tv[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    int wait_n;
    logic seen;

    // IF-only fetch (T1), IF+DM collision (T2), misaligned/illegal DM and byte store (T4)
    tv.push_back(V(1,'h40, 0,0,0,0,0,        1,0,2,'h40,0,   0,0,0, 1,0, 0));
    tv.push_back(V(1,'h40, 0,0,0,0,0,        0,0,0,0,0,      0,0,0, 1,0, 0));
    tv.push_back(V(1,'h40, 0,0,0,0,0,        0,0,0,0,0,      0,0,0, 1,0, 0));
    tv.push_back(V(1,'h40, 0,0,0,0,0,        0,0,0,0,0,      1,0,0, 0,0, 'h2010_0005));
    tv.push_back(V(0,0,    0,0,0,0,0,        0,0,0,0,0,      0,0,0, 0,0, 0));
    tv.push_back(V(1,'h80, 1,0,2,'h100,0,    1,0,2,'h100,0,  0,0,0, 1,1, 0));
    tv.push_back(V(1,'h80, 1,0,2,'h100,0,    0,0,0,0,0,      0,0,0, 1,1, 0));
    tv.push_back(V(1,'h80, 1,0,2,'h100,0,    0,0,0,0,0,      0,0,0, 1,1, 0));
    tv.push_back(V(1,'h80, 1,0,2,'h100,0,    0,0,0,0,0,      0,1,0, 1,0, 'h2010_0145));
    tv.push_back(V(1,'h80, 0,0,0,0,0,        1,0,2,'h80,0,   0,0,0, 1,0, 0));
    tv.push_back(V(1,'h80, 0,0,0,0,0,        0,0,0,0,0,      0,0,0, 1,0, 0));
    tv.push_back(V(1,'h80, 0,0,0,0,0,        0,0,0,0,0,      0,0,0, 1,0, 0));
    tv.push_back(V(1,'h80, 0,0,0,0,0,        0,0,0,0,0,      1,0,0, 0,0, 'h2010_00C5));
    tv.push_back(V(0,0,    0,0,0,0,0,        0,0,0,0,0,      0,0,0, 0,0, 0));
    tv.push_back(V(0,0,    1,1,1,'h103,'h1234, 0,0,0,0,0,    0,0,0, 0,1, 0));
    tv.push_back(V(0,0,    1,1,1,'h103,'h1234, 0,0,0,0,0,    0,1,1, 0,0, 0));
    tv.push_back(V(0,0,    1,1,0,'h103,'hAB, 1,1,0,'h103,'hAB, 0,0,0, 0,1, 0));
    tv.push_back(V(0,0,    1,1,0,'h103,'hAB, 0,0,0,0,0,      0,0,0, 0,1, 0));
    tv.push_back(V(0,0,    1,1,0,'h103,'hAB, 0,0,0,0,0,      0,0,0, 0,1, 0));
    tv.push_back(V(0,0,    1,1,0,'h103,'hAB, 0,0,0,0,0,      0,1,0, 0,0, 0));
    tv.push_back(V(0,0,    0,0,0,0,0,        0,0,0,0,0,      0,0,0, 0,0, 0));
    tv.push_back(V(0,0,    1,0,2,'h102,0,    0,0,0,0,0,      0,0,0, 0,1, 0));
    tv.push_back(V(0,0,    1,0,2,'h102,0,    0,0,0,0,0,      0,1,1, 0,0, 0));
    tv.push_back(V(0,0,    1,0,3,'h100,0,    0,0,0,0,0,      0,0,0, 0,1, 0));
    tv.push_back(V(0,0,    1,0,3,'h100,0,    0,0,0,0,0,      0,1,1, 0,0, 0));
    tv.push_back(V(0,0,    0,0,0,0,0,        0,0,0,0,0,      0,0,0, 0,0, 0));

    Reset = 1'b0; IfReq = 1'b0; IfAddr = '0; DmReq = 1'b0; DmWe = 1'b0;
    DmSize = 2'd0; DmAddr = '0; DmWdata = '0; IfReq2 = 1'b0; IfAddr2 = '0;
    @(negedge Clk);
    @(negedge Clk);
    #1;
    chk("rst.MemEn",   32'(MemEn),   0);
    chk("rst.IfValid", 32'(IfValid), 0);
    chk("rst.DmValid", 32'(DmValid), 0);
    chk("rst.DmErr",   32'(DmErr),   0);
    chk("rst.IfRdata", IfRdata,      0);
    chk("rst.DmRdata", DmRdata,      0);
    @(negedge Clk);
    Reset = 1'b1;

    foreach (tv[i]) begin
      @(negedge Clk);
      IfReq = tv[i].ifreq;   IfAddr = tv[i].ifaddr;
      DmReq = tv[i].dmreq;   DmWe = tv[i].dmwe;     DmSize = tv[i].dmsize;
      DmAddr = tv[i].dmaddr; DmWdata = tv[i].dmwdata;
      #1;
      chk($sformatf("v%0d.MemEn", i), 32'(MemEn), 32'(tv[i].e_memen));
      if (tv[i].e_memen) begin
        chk($sformatf("v%0d.MemWe", i),    32'(MemWe),   32'(tv[i].e_memwe));
        chk($sformatf("v%0d.MemSize", i),  32'(MemSize), 32'(tv[i].e_memsize));
        chk($sformatf("v%0d.MemAddr", i),  MemAddr,      tv[i].e_memaddr);
        chk($sformatf("v%0d.MemWdata", i), MemWdata,     tv[i].e_memwdata);
      end
      chk($sformatf("v%0d.IfValid", i),  32'(IfValid),  32'(tv[i].e_ifv));
      chk($sformatf("v%0d.DmValid", i),  32'(DmValid),  32'(tv[i].e_dmv));
      chk($sformatf("v%0d.DmErr", i),    32'(DmErr),    32'(tv[i].e_err));
      chk($sformatf("v%0d.StallIF", i),  32'(StallIF),  32'(tv[i].e_stif));
      chk($sformatf("v%0d.StallMEM", i), 32'(StallMEM), 32'(tv[i].e_stmem));
      if (tv[i].e_ifv) chk($sformatf("v%0d.IfRdata", i), IfRdata, tv[i].e_rdata);
      if (tv[i].e_dmv) chk($sformatf("v%0d.DmRdata", i), DmRdata, tv[i].e_rdata);
    end
    chk("hold.IfRdata", IfRdata, 32'h2010_00C5);
    chk("hold.DmRdata", DmRdata, 32'h0);

    // Starvation: both requesters held; pattern must be DM x4, IF, DM x4, IF.
    @(negedge Clk);
    IfReq = 1'b1; IfAddr = 32'h300;
    DmReq = 1'b1; DmWe = 1'b0; DmSize = 2'd2; DmAddr = 32'h200;
    g = 0;
    for (int c = 0; c < 60 && g < 10; c++) begin
      if (c != 0) @(negedge Clk);
      #1;
      if (MemEn) begin
        chk($sformatf("T3.grant%0d", g), MemAddr, (g % 5 == 4) ? 32'h300 : 32'h200);
        g++;
      end
    end
    chk("T3.grants", 32'(g), 10);
    IfReq = 1'b0; DmReq = 1'b0;

    // Reset during an access: everything clears, the abandoned read never returns.
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); IfReq = 1'b1; IfAddr = 32'h40;
    #1 chk("T5.issue", 32'(MemEn), 1);
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("T5.MemEn",   32'(MemEn),   0);
    chk("T5.MemWe",   32'(MemWe),   0);
    chk("T5.MemAddr", MemAddr,      0);
    chk("T5.IfValid", 32'(IfValid), 0);
    chk("T5.DmValid", 32'(DmValid), 0);
    chk("T5.DmErr",   32'(DmErr),   0);
    chk("T5.IfRdata", IfRdata,      0);
    chk("T5.DmRdata", DmRdata,      0);
    IfReq = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      #1 chk($sformatf("T5.quiet%0d", c), {29'd0, IfValid, DmValid, MemEn}, 0);
    end
    @(negedge Clk); IfReq = 1'b1; IfAddr = 32'h44;
    #1;
    chk("T5.reissue", 32'(MemEn), 1);
    chk("T5.readdr",  MemAddr,    32'h44);
    wait_n = 0; seen = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge Clk);
      #1;
      if (IfValid) begin
        seen = 1'b1;
        wait_n = c;
      end
    end
    chk("T5.latency", 32'(wait_n), 3);
    chk("T5.rdata",   IfRdata,     32'h2010_0001);
    @(negedge Clk); IfReq = 1'b0;

    // MEM_LAT=1 instance: held fetch request issues every 3 cycles, 1-cycle Valid.
    @(negedge Clk); IfReq2 = 1'b1; IfAddr2 = 32'h500;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge Clk);
      #1;
      chk($sformatf("T6.MemEn%0d", c),   32'(MemEn2),   32'(c % 3 == 0));
      chk($sformatf("T6.IfValid%0d", c), 32'(IfValid2), 32'(c % 3 == 2));
      if (c % 3 == 2) chk($sformatf("T6.rdata%0d", c), IfRdata2, 32'h2010_0545);
    end
    IfReq2 = 1'b0;
    @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
